// File: rtl/div_iterative.sv
// Multicycle signed integer divider: restoring division on operand magnitudes,
// one quotient bit per cycle, sign fix-up and a one-cycle ready pulse at the end.
module div_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_r;
  logic             fix_pub_r;
  logic             sign_a_r;
  logic             sign_q_r;
  logic             ovf_r;
  logic [WIDTH-1:0] mag_b_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] res_q_r;
  logic [WIDTH-1:0] res_rem_r;
  logic             res_exc_r;

  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   diff_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_next_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? negate(v) : v;
  endfunction

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    rem_shift_s = {rem_r, quo_r[WIDTH-1]};
    diff_s      = rem_shift_s - {1'b0, mag_b_r};
    ge_s        = ~diff_s[WIDTH];
    if (ge_s) begin
      rem_next_s = diff_s[WIDTH-1:0];
    end else begin
      rem_next_s = rem_shift_s[WIDTH-1:0];
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= IDLE;
      fix_pub_r      <= 1'b0;
      sign_a_r       <= 1'b0;
      sign_q_r       <= 1'b0;
      ovf_r          <= 1'b0;
      mag_b_r        <= '0;
      quo_r          <= '0;
      rem_r          <= '0;
      cnt_r          <= '0;
      res_q_r        <= '0;
      res_rem_r      <= '0;
      res_exc_r      <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        // A start is honoured in every state; an op in flight is dropped silently.
        sign_a_r <= data_operandA[WIDTH-1];
        sign_q_r <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        ovf_r    <= (data_operandA == MIN_W) && (data_operandB == {WIDTH{1'b1}});
        mag_b_r  <= magnitude(data_operandB);
        quo_r    <= magnitude(data_operandA);
        rem_r    <= '0;
        cnt_r    <= '0;
        if (data_operandB == '0) begin
          res_q_r   <= '0;
          res_rem_r <= '0;
          res_exc_r <= 1'b1;
          fix_pub_r <= 1'b1;
          state_r   <= FIX;
        end else begin
          fix_pub_r <= 1'b0;
          state_r   <= RUN;
        end
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          RUN: begin
            rem_r <= rem_next_s;
            quo_r <= {quo_r[WIDTH-2:0], ge_s};
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              state_r <= FIX;
            end else begin
              state_r <= RUN;
            end
          end
          FIX: begin
            if (!fix_pub_r) begin
              res_q_r   <= sign_q_r ? negate(quo_r) : quo_r;
              res_rem_r <= sign_a_r ? negate(rem_r) : rem_r;
              res_exc_r <= ovf_r;
              fix_pub_r <= 1'b1;
            end else begin
              data_result    <= res_q_r;
              data_remainder <= res_rem_r;
              data_exception <= res_exc_r;
              data_resultRDY <= 1'b1;
              fix_pub_r      <= 1'b0;
              state_r        <= IDLE;
            end
          end
          default: begin
            fix_pub_r <= 1'b0;
            state_r   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
